// File: rtl/cta_wg_done_queue.sv
// Show-ahead completion queue between the CTA scheduler and the host bridge; one-cycle push-to-visible latency.
// Both handshakes are driven from registered pointers only, with a saturating delivered counter and an occupancy high-water mark.
`ifndef WG_ID_WIDTH
`define WG_ID_WIDTH 8
`endif

module cta_wg_done_queue #(
    parameter int DEPTH   = 8,
    parameter int WG_ID_W = `WG_ID_WIDTH,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wg_done_valid_i,
    output logic                     wg_done_ready_o,
    input  logic [WG_ID_W-1:0]       wg_done_wg_id_i,
    output logic                     host_rsp_valid_o,
    input  logic                     host_rsp_ready_i,
    output logic [WG_ID_W-1:0]       host_rsp_wg_id_o,
    input  logic                     clear_cnt_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [$clog2(DEPTH):0]   max_occ_o,
    output logic [CNT_W-1:0]         done_cnt_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      max_occ_q, max_occ_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic [WG_ID_W-1:0] mem_q [DEPTH];
    logic [WG_ID_W-1:0] mem_d [DEPTH];

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [PW-1:0] occ_cur;
    logic [PW-1:0] occ_next;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign occ_cur = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wg_done_ready_o  = !full;
    assign host_rsp_valid_o = !empty;
    assign push             = wg_done_valid_i && wg_done_ready_o;
    assign pop              = host_rsp_valid_o && host_rsp_ready_i;

    // Head is gated so a stale slot never shows through while the queue is empty.
    assign host_rsp_wg_id_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign occupancy_o = occ_cur;
    assign max_occ_o   = max_occ_q;
    assign done_cnt_o  = done_cnt_q;
    assign empty_o     = empty;
    assign full_o      = full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wg_done_wg_id_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    assign occ_next = wr_ptr_d - rd_ptr_d;

    always_comb begin
        max_occ_d = max_occ_q;
        if (clear_cnt_i) begin
            max_occ_d = occ_next;
        end else if (occ_next > max_occ_q) begin
            max_occ_d = occ_next;
        end
    end

    // Clear wins over a same-cycle delivery so software reads a clean zero.
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (clear_cnt_i) begin
            done_cnt_d = '0;
        end else if (pop && (done_cnt_q != {CNT_W{1'b1}})) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            max_occ_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            max_occ_q  <= max_occ_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wg_done_valid_i && wg_done_ready_o && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(host_rsp_valid_o && host_rsp_ready_i && empty));

endmodule

// File: tb/tb_cta_wg_done_queue.sv
// Scoreboard bench for cta_wg_done_queue: expected IDs queued at push, compared at pop.
module tb_cta_wg_done_queue;

    localparam int DEPTH = 8;
    localparam int IDW   = 8;
    localparam int CW    = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           v_i = 1'b0;
    logic [IDW-1:0] id_i = '0;
    logic           r_i = 1'b0;
    logic           clr_i = 1'b0;
    logic           rdy_o;
    logic           vld_o;
    logic [IDW-1:0] id_o;
    logic [3:0]     occ_o;
    logic [3:0]     max_o;
    logic [CW-1:0]  cnt_o;
    logic           empty_o;
    logic           full_o;

    int checks   = 0;
    int failures = 0;
    logic [IDW-1:0] exp_q [$];
    int exp_cnt = 0;
    int exp_max = 0;

    cta_wg_done_queue #(.DEPTH(DEPTH), .WG_ID_W(IDW), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .wg_done_valid_i  (v_i),
        .wg_done_ready_o  (rdy_o),
        .wg_done_wg_id_i  (id_i),
        .host_rsp_valid_o (vld_o),
        .host_rsp_ready_i (r_i),
        .host_rsp_wg_id_o (id_o),
        .clear_cnt_i      (clr_i),
        .occupancy_o      (occ_o),
        .max_occ_o        (max_o),
        .done_cnt_o       (cnt_o),
        .empty_o          (empty_o),
        .full_o           (full_o)
    );

    always #5 clk = ~clk;

    // Advances one edge while updating the reference model; returns the head seen before the edge.
    task automatic tick(output bit popped, output logic [IDW-1:0] got, output logic [IDW-1:0] want);
        bit push;
        int occ;
        push   = v_i && (exp_q.size() < DEPTH);
        popped = r_i && (exp_q.size() > 0);
        got    = id_o;
        want   = popped ? exp_q[0] : '0;
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
            exp_max = 0;
            popped  = 1'b0;
        end else begin
            if (popped) begin
                void'(exp_q.pop_front());
                if (!clr_i && exp_cnt != 15) exp_cnt++;
            end
            if (push) exp_q.push_back(id_i);
            if (clr_i) exp_cnt = 0;
            occ = exp_q.size();
            if (clr_i || occ > exp_max) exp_max = occ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [IDW-1:0] id, input bit r, input bit clr);
        v_i   = v;
        id_i  = id;
        r_i   = r;
        clr_i = clr;
    endtask

    task automatic test_reset;
        bit p; logic [IDW-1:0] g, w;
        rst = 1'b1;
        drive(0, 8'h00, 0, 0);
        tick(p, g, w);
        tick(p, g, w);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(p, g, w);
        checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", vld_o); end
        checks++; if (rdy_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", rdy_o); end
        checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", empty_o, full_o); end
        checks++; if (occ_o !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ_o); end
        checks++; if (cnt_o !== 4'd0 || max_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got cnt=%0d max=%0d exp 0/0", cnt_o, max_o); end
        checks++; if (id_o !== 8'h00) begin failures++; $display("FAIL reset_id got=%0h exp=0", id_o); end
    endtask

    task automatic test_basic;
        bit p; logic [IDW-1:0] g, w;
        logic [IDW-1:0] ids [3];
        ids[0] = 8'h11; ids[1] = 8'h22; ids[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1, ids[i], 0, 0);
            tick(p, g, w);
            if (i == 0) begin
                checks++; if (vld_o !== 1'b1 || id_o !== 8'h11) begin failures++; $display("FAIL latency got vld=%0b id=%0h exp vld=1 id=11", vld_o, id_o); end
            end
        end
        drive(0, 8'h00, 0, 0);
        checks++; if (occ_o !== 4'd3) begin failures++; $display("FAIL basic_occ got=%0d exp=3", occ_o); end
        checks++; if (id_o !== 8'h11) begin failures++; $display("FAIL basic_head got=%0h exp=11", id_o); end
        drive(0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(p, g, w);
            checks++; if (!p || g !== w || g !== ids[i]) begin failures++; $display("FAIL basic_pop%0d got=%0h exp=%0h popped=%0b", i, g, ids[i], p); end
        end
        drive(0, 8'h00, 0, 0);
        checks++; if (cnt_o !== 4'd3) begin failures++; $display("FAIL basic_cnt got=%0d exp=3", cnt_o); end
        checks++; if (empty_o !== 1'b1 || vld_o !== 1'b0) begin failures++; $display("FAIL basic_empty got empty=%0b vld=%0b exp 1/0", empty_o, vld_o); end
    endtask

    task automatic test_full;
        bit p; logic [IDW-1:0] g, w;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(i), 0, 0);
            tick(p, g, w);
        end
        checks++; if (full_o !== 1'b1 || rdy_o !== 1'b0) begin failures++; $display("FAIL full_flags got full=%0b rdy=%0b exp 1/0", full_o, rdy_o); end
        drive(1, 8'd8, 0, 0);
        tick(p, g, w);
        checks++; if (occ_o !== 4'd8 || rdy_o !== 1'b0) begin failures++; $display("FAIL full_hold got occ=%0d rdy=%0b exp 8/0", occ_o, rdy_o); end
        drive(1, 8'd8, 1, 0);
        tick(p, g, w);
        checks++; if (!p || g !== 8'd0) begin failures++; $display("FAIL full_pop0 got=%0h exp=0", g); end
        checks++; if (occ_o !== 4'd7 || rdy_o !== 1'b1) begin failures++; $display("FAIL full_reopen got occ=%0d rdy=%0b exp 7/1", occ_o, rdy_o); end
        drive(1, 8'd8, 0, 0);
        tick(p, g, w);
        checks++; if (occ_o !== 4'd8 || full_o !== 1'b1) begin failures++; $display("FAIL full_ninth got occ=%0d full=%0b exp 8/1", occ_o, full_o); end
        drive(0, 8'h00, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(p, g, w);
            checks++; if (!p || g !== w || g !== 8'(i)) begin failures++; $display("FAIL full_drain%0d got=%0h exp=%0h", i, g, i); end
        end
        drive(0, 8'h00, 0, 0);
        checks++; if (empty_o !== 1'b1 || cnt_o !== 4'(exp_cnt)) begin failures++; $display("FAIL full_end got empty=%0b cnt=%0d exp 1/%0d", empty_o, cnt_o, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        bit p; logic [IDW-1:0] g, w;
        drive(0, 8'h00, 0, 1);
        tick(p, g, w);
        checks++; if (max_o !== 4'd0 || cnt_o !== 4'd0) begin failures++; $display("FAIL b2b_clear got max=%0d cnt=%0d exp 0/0", max_o, cnt_o); end
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i), 1, 0);
            tick(p, g, w);
            if (i > 0) begin
                checks++; if (!p || g !== w || g !== 8'(i - 1)) begin failures++; $display("FAIL b2b_out%0d got=%0h exp=%0h", i, g, i - 1); end
            end
            checks++; if (occ_o !== 4'd1) begin failures++; $display("FAIL b2b_occ%0d got=%0d exp=1", i, occ_o); end
        end
        drive(0, 8'h00, 1, 0);
        tick(p, g, w);
        checks++; if (!p || g !== 8'd19) begin failures++; $display("FAIL b2b_last got=%0h exp=13", g); end
        drive(0, 8'h00, 0, 0);
        checks++; if (max_o !== 4'd1) begin failures++; $display("FAIL b2b_max got=%0d exp=1", max_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0b exp=1", empty_o); end
    endtask

    task automatic test_counter;
        bit p; logic [IDW-1:0] g, w;
        drive(0, 8'h00, 0, 1);
        tick(p, g, w);
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'(8'h40 + i), 1, 0);
            tick(p, g, w);
            if (i > 0) begin
                checks++; if (!p || g !== w) begin failures++; $display("FAIL sat_data%0d got=%0h exp=%0h", i, g, w); end
            end
        end
        drive(0, 8'h00, 1, 0);
        tick(p, g, w);
        checks++; if (cnt_o !== 4'hF || cnt_o !== 4'(exp_cnt)) begin failures++; $display("FAIL sat_hold got=%0h exp=f", cnt_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h60 + i), 0, 0);
            tick(p, g, w);
        end
        drive(0, 8'h00, 1, 1);
        tick(p, g, w);
        checks++; if (!p || g !== 8'h60) begin failures++; $display("FAIL clr_pop got=%0h exp=60", g); end
        checks++; if (cnt_o !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", cnt_o); end
        checks++; if (max_o !== 4'd2 || max_o !== 4'(exp_max)) begin failures++; $display("FAIL clr_max got=%0d exp=2", max_o); end
        drive(0, 8'h00, 1, 0);
        for (int i = 1; i < 3; i++) begin
            tick(p, g, w);
            checks++; if (!p || g !== 8'(8'h60 + i)) begin failures++; $display("FAIL clr_drain%0d got=%0h exp=%0h", i, g, 8'h60 + i); end
        end
        drive(0, 8'h00, 0, 0);
    endtask

    task automatic test_reset_mid;
        bit p; logic [IDW-1:0] g, w;
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h80 + i), 0, 0);
            tick(p, g, w);
        end
        checks++; if (occ_o !== 4'd5) begin failures++; $display("FAIL rmid_pre got=%0d exp=5", occ_o); end
        drive(1, 8'hAA, 0, 0);
        rst = 1'b1;
        tick(p, g, w);
        rst = 1'b0;
        drive(0, 8'h00, 0, 0);
        checks++; if (occ_o !== 4'd0 || vld_o !== 1'b0) begin failures++; $display("FAIL rmid_occ got occ=%0d vld=%0b exp 0/0", occ_o, vld_o); end
        checks++; if (cnt_o !== 4'd0 || id_o !== 8'h00) begin failures++; $display("FAIL rmid_cnt got cnt=%0d id=%0h exp 0/0", cnt_o, id_o); end
        tick(p, g, w);
        checks++; if (empty_o !== 1'b1 || rdy_o !== 1'b1 || occ_o !== 4'(exp_q.size())) begin failures++; $display("FAIL rmid_nostore got empty=%0b rdy=%0b occ=%0d exp 1/1/0", empty_o, rdy_o, occ_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_counter();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cta_wg_done_queue.md
Name: cta_wg_done_queue

Overview:
- Buffers workgroup-completion events from the CTA scheduler's inflight WG buffer before they reach the AXI4-Lite host bridge.
- The host bridge holds only one done WG ID until the host reads and clears it. Without a queue, back-to-back completions stall the scheduler.
- The block is a show-ahead FIFO with valid/ready on both sides, a delivered-completion counter and an occupancy high-water mark for debug.

Parameters:
- DEPTH, 8, number of queued completion entries; power of two, minimum 2.
- WG_ID_W, `WG_ID_WIDTH, width of a workgroup ID.
- CNT_W, 32, width of the delivered-completion counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; synchronous, active-high.
- wg_done_valid_i  input  1  completion event valid, from the scheduler.
- wg_done_ready_o  output  1  queue can accept an event.
- wg_done_wg_id_i  input  WG_ID_W  ID of the completed workgroup.
- host_rsp_valid_o  output  1  head entry valid, to the host bridge.
- host_rsp_ready_i  input  1  host bridge accepts the head entry.
- host_rsp_wg_id_o  output  WG_ID_W  head entry WG ID.
- clear_cnt_i  input  1  synchronous clear of done_cnt_o and max_occ_o.
- occupancy_o  output  $clog2(DEPTH)+1  current number of entries.
- max_occ_o  output  $clog2(DEPTH)+1  high-water mark of occupancy.
- done_cnt_o  output  CNT_W  number of entries delivered to the host.
- empty_o  output  1  occupancy == 0.
- full_o  output  1  occupancy == DEPTH.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset, sampled on the clk edge while rst=1:
  - Read/write pointers, occupancy, done_cnt and max_occ all go to 0.
  - host_rsp_valid_o=0, host_rsp_wg_id_o=0, wg_done_ready_o=1 once rst deasserts.
  - empty_o=1, full_o=0.
  - Reset mid-operation discards all queued entries with no partial delivery.
- Push:
  - wg_done_ready_o = !full_o, registered-state only; it does not depend on host_rsp_ready_i.
  - A push occurs on wg_done_valid_i && wg_done_ready_o; it writes the ID at the write pointer and advances the pointer modulo DEPTH.
- Pop:
  - host_rsp_valid_o = !empty_o, driven from registered state only. It must not depend combinationally on host_rsp_ready_i, because the bridge's ready is a function of valid.
  - host_rsp_wg_id_o always presents the entry at the read pointer (show-ahead).
  - A pop occurs on host_rsp_valid_o && host_rsp_ready_i and advances the read pointer modulo DEPTH.
- Latency: an event pushed at edge N is visible on host_rsp_valid_o/host_rsp_wg_id_o after edge N (one cycle, no combinational bypass).
- Simultaneous push and pop:
  - When neither empty nor full, occupancy is unchanged.
  - When full, ready=0, so only the pop happens; ready rises the next cycle.
  - When empty, valid=0, so only the push happens.
- Ordering is strict FIFO; IDs are delivered unmodified.
- Pointer wrap: pointers carry one extra MSB. full = (ptrs differ only in MSB), empty = (ptrs equal). occupancy_o = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- done_cnt_o:
  - Increments by 1 on each pop and saturates at all-ones.
  - clear_cnt_i has priority: a pop in the same cycle as a clear leaves the counter at 0.
- max_occ_o:
  - Each cycle, max_occ_o <= max(max_occ_o, next occupancy).
  - clear_cnt_i loads it with the next occupancy, not 0.
- No overflow or underflow is possible by construction. Assert in simulation that push never occurs when full and pop never occurs when empty.

Test Plan:
- Reset, then idle 5 cycles -> valid=0, ready=1, empty=1, occupancy=0, done_cnt=0.
- Push IDs 0x11, 0x22, 0x33 with host_rsp_ready_i=0 -> occupancy=3, head=0x11. Then hold ready=1 -> 0x11, 0x22, 0x33 pop on consecutive cycles, done_cnt=3, empty=1.
- Push 8 IDs 0..7 with DEPTH=8 and ready_i=0 -> full=1, wg_done_ready_o=0. A 9th valid is held and not accepted. One pop -> ready=1 next cycle and the 9th ID enters; drain order is 1..8.
- Continuous push and pop every cycle for 20 cycles, IDs 0..19 -> occupancy stays at 1, output sequence is 0..19 in order, pointers wrap twice, max_occ=1.
- Preload done_cnt to all-ones (force CNT_W=4, 16 pops) and pop once more -> stays 0xF. clear_cnt_i with a simultaneous pop -> done_cnt=0. Occupancy at 2 when clear is asserted -> max_occ=2.
- Assert rst for one cycle while 5 entries are queued and a push is in flight -> after reset occupancy=0, valid=0, done_cnt=0, and the in-flight push is not stored.
